// File: rtl/guess_capture.sv
// rtl/guess_capture.sv - button synchroniser, debouncer and one-shot guess request generator
//
// Purpose:
//   Front end of the whack-a-mole guess path. Eight raw hole buttons are
//   synchronised, debounced as a whole vector and classified. A single
//   stable press becomes a 3-bit hole index with a one-cycle eval_now
//   request. Each press produces at most one request; every button must be
//   released before the next press is considered.
//
// Ports:
//   clk            in   1  system clock
//   rst_n          in   1  asynchronous active-low reset
//   btn            in   8  raw hole buttons, active-high, asynchronous to clk
//   guess_now      in   1  evaluator ready, 1 = guesses accepted
//   i_restart_game in   1  synchronous game restart (debounce state is kept)
//   i_game_over    in   1  game finished, no new guesses forwarded
//   user_guess     out  3  encoded hole index, held until the next accepted guess
//   eval_now       out  1  one-cycle guess request
//   multi_press    out  1  one-cycle pulse when two or more buttons are stably pressed
//   busy           out  1  high whenever the FSM is not ARMED
//
// Optional feature macro: GUESS_LATCH_EN
//   When defined, a single press seen while guess_now=0 (and the game is
//   running) is latched and held in a PENDING state until guess_now rises.

module guess_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn,
    input  logic       guess_now,
    input  logic       i_restart_game,
    input  logic       i_game_over,
    output logic [2:0] user_guess,
    output logic       eval_now,
    output logic       multi_press,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_FIRE     = 3'd2,
        S_WAIT_REL = 3'd3
`ifdef GUESS_LATCH_EN
        ,
        S_PENDING  = 3'd4
`endif
    } state_t;

    logic [7:0]       sync_1;
    logic [7:0]       btn_s;
    logic [7:0]       btn_prev;
    logic [7:0]       btn_db;
    logic [CNT_W-1:0] db_cnt;
    logic             btn_same;

    state_t           state;
    state_t           next_state;
    logic [2:0]       guess_d;
    logic             eval_d;
    logic             multi_d;

    logic [3:0]       db_ones;
    logic [2:0]       db_idx;
    logic             db_none;
    logic             db_one;
    logic             db_multi;

    // Two-flop synchroniser per button bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            btn_s  <= '0;
        end else begin
            sync_1 <= btn;
            btn_s  <= sync_1;
        end
    end

    assign btn_same = (btn_s == btn_prev);

    // Whole-vector debounce: any change restarts the count. The load of
    // btn_db is qualified with btn_same so that a change arriving while the
    // counter sits saturated is never taken without a fresh full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= '0;
            db_cnt   <= '0;
            btn_db   <= '0;
        end else begin
            btn_prev <= btn_s;
            if (!btn_same) begin
                db_cnt <= '0;
            end else if (db_cnt != CNT_LAST) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (btn_same && (db_cnt == CNT_LAST)) begin
                btn_db <= btn_s;
            end
        end
    end

    // Classify the debounced vector: none, exactly one (with its index), or several.
    always_comb begin
        db_ones = '0;
        db_idx  = '0;
        for (int i = 0; i < 8; i++) begin
            if (btn_db[i]) begin
                db_ones = db_ones + 4'd1;
                db_idx  = 3'(i);
            end
        end
    end

    assign db_none  = (db_ones == 4'd0);
    assign db_one   = (db_ones == 4'd1);
    assign db_multi = (db_ones >= 4'd2);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            user_guess  <= '0;
            eval_now    <= 1'b0;
            multi_press <= 1'b0;
        end else begin
            state       <= next_state;
            user_guess  <= guess_d;
            eval_now    <= eval_d;
            multi_press <= multi_d;
        end
    end

    // Next-state logic. eval_now is registered from next_state so that it is
    // high exactly while the FSM sits in FIRE, and a restart cancels it.
    always_comb begin
        next_state = state;
        guess_d    = user_guess;
        multi_d    = 1'b0;
        if (i_restart_game) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    // Buttons held through reset or restart must be released first.
                    if (db_none) begin
                        next_state = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (db_multi) begin
                        multi_d    = 1'b1;
                        next_state = S_WAIT_REL;
                    end else if (db_one) begin
                        if (guess_now && !i_game_over) begin
                            guess_d    = db_idx;
                            next_state = S_FIRE;
`ifdef GUESS_LATCH_EN
                        end else if (!i_game_over) begin
                            guess_d    = db_idx;
                            next_state = S_PENDING;
`endif
                        end else begin
                            next_state = S_WAIT_REL;
                        end
                    end
                end
                S_FIRE: begin
                    // Pulse is committed; game-over does not suppress it here.
                    next_state = S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (db_none) begin
                        next_state = S_ARMED;
                    end
                end
`ifdef GUESS_LATCH_EN
                S_PENDING: begin
                    // Release does not cancel a latched guess.
                    if (i_game_over) begin
                        next_state = S_WAIT_REL;
                    end else if (guess_now) begin
                        next_state = S_FIRE;
                    end
                end
`endif
                default: begin
                    next_state = S_IDLE;
                end
            endcase
        end
        eval_d = (next_state == S_FIRE);
    end

    assign busy = (state != S_ARMED);

endmodule
